// File: rtl/n3_packet_buffer.sv
// rtl/n3_packet_buffer.sv - store-and-forward packet buffer with descriptor queue and streaming readout
// Optional N3_BUF_ERR_DROP_EN: discard errored packets and count them on drop_cnt_o.
module n3_packet_buffer #(
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned NUM_DESC  = 8,
    parameter int unsigned MAX_WORDS = 64
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [31:0] in_data_i,
    input  logic        in_valid_i,
    input  logic        in_sop_i,
    input  logic        in_eop_i,
    output logic        in_ready_o,
    output logic        pkt_avail_o,
    output logic [15:0] pkt_id_o,
    output logic [6:0]  pkt_len_o,
    input  logic        rd_req_i,
    output logic [31:0] packet_o,
    output logic        packet_valid_o,
    output logic        packet_last_o
`ifdef N3_BUF_ERR_DROP_EN
    ,
    output logic [15:0] drop_cnt_o
`endif
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned DW = $clog2(NUM_DESC);
    localparam logic [AW:0] WORDS_FULL   = (AW+1)'(DEPTH);
    localparam logic [DW:0] DESC_FULL    = (DW+1)'(NUM_DESC);
    localparam logic [DW:0] DESC_FULL_M1 = (DW+1)'(NUM_DESC - 1);
    localparam logic [6:0]  MAXW         = 7'(MAX_WORDS);
`ifdef N3_BUF_ERR_DROP_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, HEAD, FETCH, STREAM} rd_state_e;

    logic [31:0]   mem [DEPTH];
    logic [31:0]   ram_q;
    logic [AW-1:0] desc_start [NUM_DESC];
    logic [6:0]    desc_len   [NUM_DESC];
    logic [15:0]   desc_id    [NUM_DESC];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, pkt_start_q, pkt_start_d, rd_ptr_q, rd_ptr_d;
    logic [6:0]    pkt_len_q, pkt_len_d, rd_cnt_q, rd_cnt_d;
    logic          in_pkt_q, in_pkt_d;
    logic [AW:0]   used_q, used_d;
    logic [DW-1:0] desc_wr_q, desc_wr_d, desc_rd_q, desc_rd_d;
    logic [DW:0]   desc_cnt_q, desc_cnt_d, ncommit;
    logic [15:0]   id_cnt_q, id_cnt_d;
    rd_state_e     state_q, state_d;

    logic          accept, sop_err, len_err, start_new, cont, wr_en, rewind;
    logic          commit_old, commit_new, rd_en, pop, last;
    logic [AW-1:0] new_start, wr_addr, head_start;
    logic [6:0]    old_len, head_len;
    logic [15:0]   head_id;
    logic [DW-1:0] new_idx;

    assign head_start = desc_start[desc_rd_q];
    assign head_len   = desc_len[desc_rd_q];
    assign head_id    = desc_id[desc_rd_q];

    // An in-packet SOP without drop closes the old packet and opens a new one, so it needs two free slots.
    always_comb begin
        in_ready_o = 1'b0;
        if (!reset && used_q < WORDS_FULL) begin
            if (!in_sop_i)
                in_ready_o = 1'b1;
            else if (in_pkt_q && !DROP_EN)
                in_ready_o = desc_cnt_q < DESC_FULL_M1;
            else
                in_ready_o = desc_cnt_q < DESC_FULL;
        end
    end

    assign accept    = in_valid_i && in_ready_o;
    assign start_new = accept && in_sop_i;
    assign sop_err   = start_new && in_pkt_q;
    assign len_err   = accept && !in_sop_i && in_pkt_q && (pkt_len_q == MAXW);
    assign cont      = accept && !in_sop_i && in_pkt_q && !len_err;

    always_comb begin
        rewind      = DROP_EN && (sop_err || len_err);
        new_start   = (DROP_EN && sop_err) ? pkt_start_q : wr_ptr_q;
        wr_en       = start_new || cont;
        wr_addr     = start_new ? new_start : wr_ptr_q;
        commit_old  = (cont && in_eop_i) || (!DROP_EN && (sop_err || len_err));
        commit_new  = start_new && in_eop_i;
        old_len     = cont ? pkt_len_q + 7'd1 : pkt_len_q;
        new_idx     = desc_wr_q + DW'(commit_old);
        ncommit     = (DW+1)'(commit_old) + (DW+1)'(commit_new);
        wr_ptr_d    = wr_en ? wr_addr + AW'(1) : (rewind ? pkt_start_q : wr_ptr_q);
        pkt_start_d = start_new ? new_start : pkt_start_q;
        pkt_len_d   = start_new ? 7'd1 : (cont ? pkt_len_q + 7'd1 : pkt_len_q);
        in_pkt_d    = in_pkt_q;
        if (start_new || cont)
            in_pkt_d = !in_eop_i;
        else if (len_err)
            in_pkt_d = 1'b0;
    end

    always_comb begin
        state_d  = state_q;
        rd_en    = 1'b0;
        pop      = 1'b0;
        rd_ptr_d = rd_ptr_q;
        rd_cnt_d = rd_cnt_q;
        last     = (rd_cnt_q == head_len - 7'd1);
        case (state_q)
            IDLE: if (desc_cnt_q != '0) state_d = HEAD;
            HEAD: begin
                rd_ptr_d = head_start;
                if (rd_req_i) state_d = FETCH;
            end
            FETCH: begin
                rd_en    = 1'b1;
                rd_cnt_d = 7'd0;
                state_d  = STREAM;
            end
            STREAM: begin
                rd_cnt_d = rd_cnt_q + 7'd1;
                if (last) begin
                    pop     = 1'b1;
                    state_d = (desc_cnt_q > (DW+1)'(1) || ncommit != '0) ? HEAD : IDLE;
                end else begin
                    rd_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
        used_d     = used_q + (AW+1)'(wr_en)
                     - (pop ? (AW+1)'(head_len) : '0)
                     - (rewind ? (AW+1)'(pkt_len_q) : '0);
        desc_cnt_d = desc_cnt_q + ncommit - (DW+1)'(pop);
        desc_wr_d  = desc_wr_q + DW'(ncommit);
        desc_rd_d  = desc_rd_q + DW'(pop);
        id_cnt_d   = id_cnt_q + 16'(ncommit);
    end

    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_addr] <= in_data_i;
        if (rd_en) ram_q <= mem[rd_ptr_q];
        if (commit_old) begin
            desc_start[desc_wr_q] <= pkt_start_q;
            desc_len[desc_wr_q]   <= old_len;
            desc_id[desc_wr_q]    <= id_cnt_q;
        end
        if (commit_new) begin
            desc_start[new_idx] <= new_start;
            desc_len[new_idx]   <= 7'd1;
            desc_id[new_idx]    <= id_cnt_q + 16'(commit_old);
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            pkt_start_q <= '0;
            pkt_len_q   <= '0;
            in_pkt_q    <= 1'b0;
            used_q      <= '0;
            desc_wr_q   <= '0;
            desc_rd_q   <= '0;
            desc_cnt_q  <= '0;
            id_cnt_q    <= '0;
            rd_ptr_q    <= '0;
            rd_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            pkt_start_q <= pkt_start_d;
            pkt_len_q   <= pkt_len_d;
            in_pkt_q    <= in_pkt_d;
            used_q      <= used_d;
            desc_wr_q   <= desc_wr_d;
            desc_rd_q   <= desc_rd_d;
            desc_cnt_q  <= desc_cnt_d;
            id_cnt_q    <= id_cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_cnt_q    <= rd_cnt_d;
        end
    end

`ifdef N3_BUF_ERR_DROP_EN
    logic [15:0] drop_cnt_q;
    always_ff @(posedge CLK) begin
        if (reset)
            drop_cnt_q <= '0;
        else if ((sop_err || len_err) && drop_cnt_q != 16'hFFFF)
            drop_cnt_q <= drop_cnt_q + 16'd1;
    end
    assign drop_cnt_o = reset ? 16'd0 : drop_cnt_q;
`endif

    assign pkt_avail_o    = !reset && (state_q == HEAD);
    assign pkt_id_o       = (!reset && state_q != IDLE) ? head_id : 16'd0;
    assign pkt_len_o      = (!reset && state_q != IDLE) ? head_len : 7'd0;
    assign packet_valid_o = !reset && (state_q == STREAM);
    assign packet_o       = packet_valid_o ? ram_q : 32'd0;
    assign packet_last_o  = packet_valid_o && last;
endmodule

// File: tb/tb_n3_packet_buffer.sv
// tb/tb_n3_packet_buffer.sv - directed self-checking bench for n3_packet_buffer
module tb_n3_packet_buffer;
    logic        CLK = 1'b0;
    logic        reset;
    logic [31:0] in_data_i;
    logic        in_valid_i, in_sop_i, in_eop_i, in_ready_o;
    logic        pkt_avail_o;
    logic [15:0] pkt_id_o;
    logic [6:0]  pkt_len_o;
    logic        rd_req_i;
    logic [31:0] packet_o;
    logic        packet_valid_o, packet_last_o;
`ifdef N3_BUF_ERR_DROP_EN
    logic [15:0] drop_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    n3_packet_buffer dut (
        .CLK(CLK), .reset(reset),
        .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_sop_i(in_sop_i),
        .in_eop_i(in_eop_i), .in_ready_o(in_ready_o),
        .pkt_avail_o(pkt_avail_o), .pkt_id_o(pkt_id_o), .pkt_len_o(pkt_len_o),
        .rd_req_i(rd_req_i), .packet_o(packet_o),
        .packet_valid_o(packet_valid_o), .packet_last_o(packet_last_o)
`ifdef N3_BUF_ERR_DROP_EN
        , .drop_cnt_o(drop_cnt_o)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic send_word(input logic [31:0] data, input logic sop, input logic eop);
        in_valid_i = 1'b1;
        in_data_i  = data;
        in_sop_i   = sop;
        in_eop_i   = eop;
        #1;
        check("in_ready", 32'(in_ready_o), 32'd1);
        tick();
        in_valid_i = 1'b0;
        in_sop_i   = 1'b0;
        in_eop_i   = 1'b0;
        #1;
    endtask

    task automatic send_pkt(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++)
            send_word(base + 32'(i), i == 0, i == n - 1);
    endtask

    task automatic read_pkt(input int n, input logic [31:0] base, input logic [15:0] id, input string tag);
        int w = 0;
        while (!pkt_avail_o && w < 300) begin
            tick();
            w++;
        end
        check({tag, " avail"}, 32'(pkt_avail_o), 32'd1);
        check({tag, " id"}, 32'(pkt_id_o), 32'(id));
        check({tag, " len"}, 32'(pkt_len_o), 32'(n));
        rd_req_i = 1'b1;
        tick();
        rd_req_i = 1'b0;
        check({tag, " fetch_valid"}, 32'(packet_valid_o), 32'd0);
        tick();
        for (int i = 0; i < n; i++) begin
            check({tag, " valid"}, 32'(packet_valid_o), 32'd1);
            check({tag, " data"}, packet_o, base + 32'(i));
            check({tag, " last"}, 32'(packet_last_o), 32'(i == n - 1));
            check({tag, " id_hold"}, 32'(pkt_id_o), 32'(id));
            if (i < n - 1) tick();
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        in_valid_i = 1'b0;
        in_sop_i   = 1'b0;
        in_eop_i   = 1'b0;
        rd_req_i   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        in_data_i = '0;
        do_reset();
        reset      = 1'b1;
        in_valid_i = 1'b1;
        in_sop_i   = 1'b1;
        tick();
        #1;
        check("rst in_ready", 32'(in_ready_o), 32'd0);
        check("rst avail", 32'(pkt_avail_o), 32'd0);
        check("rst id", 32'(pkt_id_o), 32'd0);
        check("rst len", 32'(pkt_len_o), 32'd0);
        check("rst data", packet_o, 32'd0);
        check("rst valid", 32'(packet_valid_o), 32'd0);
        check("rst last", 32'(packet_last_o), 32'd0);
`ifdef N3_BUF_ERR_DROP_EN
        check("rst drop", 32'(drop_cnt_o), 32'd0);
`endif
        in_valid_i = 1'b0;
        in_sop_i   = 1'b0;
        reset      = 1'b0;
        tick();
        check("post_rst in_ready", 32'(in_ready_o), 32'd1);

        // Basic 3-word packet
        send_pkt(3, 32'hA000_0001);
        read_pkt(3, 32'hA000_0001, 16'h0000, "t1");
        tick();
        check("t1 end_valid", 32'(packet_valid_o), 32'd0);
        check("t1 end_avail", 32'(pkt_avail_o), 32'd0);

        // Two max-length packets, reader keeping up
        do_reset();
        fork
            begin
                send_pkt(64, 32'h1000_0000);
                send_pkt(64, 32'h2000_0000);
            end
            begin
                read_pkt(64, 32'h1000_0000, 16'h0000, "t2a");
                tick();
                check("t2 avail_no_gap", 32'(pkt_avail_o), 32'd1);
                check("t2 id2", 32'(pkt_id_o), 32'd1);
                read_pkt(64, 32'h2000_0000, 16'h0001, "t2b");
            end
        join
        tick();
        check("t2 end_valid", 32'(packet_valid_o), 32'd0);

        // Fill all words, then free a 4-word packet
        do_reset();
        send_pkt(4, 32'h3000_0000);
        for (int k = 0; k < 4; k++)
            send_pkt(63, 32'h3100_0000 + 32'(k * 256));
        check("t3 full", 32'(in_ready_o), 32'd0);
        read_pkt(4, 32'h3000_0000, 16'h0000, "t3");
        check("t3 ready_at_last", 32'(in_ready_o), 32'd0);
        tick();
        check("t3 ready_after", 32'(in_ready_o), 32'd1);

        // SOP arriving as the third word of a packet
        do_reset();
        send_word(32'hB000_0000, 1'b1, 1'b0);
        send_word(32'hB000_0001, 1'b0, 1'b0);
        send_pkt(3, 32'hC000_0000);
`ifdef N3_BUF_ERR_DROP_EN
        check("t4 drop_cnt", 32'(drop_cnt_o), 32'd1);
        read_pkt(3, 32'hC000_0000, 16'h0000, "t4");
        tick();
        tick();
        check("t4 no_more", 32'(pkt_avail_o), 32'd0);
`else
        read_pkt(2, 32'hB000_0000, 16'h0000, "t4a");
        read_pkt(3, 32'hC000_0000, 16'h0001, "t4b");
`endif

        // ID counter wrap
        do_reset();
        force dut.id_cnt_q = 16'hFFFF;
        #1;
        release dut.id_cnt_q;
        send_pkt(1, 32'hD000_0000);
        send_pkt(1, 32'hE000_0000);
        read_pkt(1, 32'hD000_0000, 16'hFFFF, "t5a");
        read_pkt(1, 32'hE000_0000, 16'h0000, "t5b");

        // Reset during the second word of a 10-word readout
        do_reset();
        send_pkt(10, 32'h5000_0000);
        begin
            int w = 0;
            while (!pkt_avail_o && w < 50) begin
                tick();
                w++;
            end
        end
        check("t6 avail", 32'(pkt_avail_o), 32'd1);
        rd_req_i = 1'b1;
        tick();
        rd_req_i = 1'b0;
        tick();
        check("t6 word0", packet_o, 32'h5000_0000);
        tick();
        check("t6 word1", packet_o, 32'h5000_0001);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("t6 valid_after_rst", 32'(packet_valid_o), 32'd0);
        check("t6 avail_after_rst", 32'(pkt_avail_o), 32'd0);
        tick();
        check("t6 avail_settled", 32'(pkt_avail_o), 32'd0);
        send_pkt(2, 32'h6000_0000);
        read_pkt(2, 32'h6000_0000, 16'h0000, "t6");

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
